debug_dump_unit: RTL and testbench

DEBUG_DUMP_UNIT -- requirements
Module: debug_dump_unit

---
 rtl/debug_dump_unit.sv | 168 ++++++++++++++++
 tb/tb_debug_dump_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_unit.sv
// debug_dump_unit
// Streams a snapshot of the CPU state over a byte-wide transmitter link.
// The frame is: HEADER, the 32 general registers (4 bytes each, MSB first),
// MEM_WORDS data-memory words (4 bytes each, MSB first), and an XOR checksum
// over every byte except HEADER.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high, clears all state
//   start        request one dump frame (ignored unless idle)
//   reg_sel      register index for the external register-array mux
//   reg_data     register value for reg_sel, same-cycle
//   debugMode    high while the data memory is being read for the dump
//   DebugAddress word index into data memory (zero-extended)
//   mem_data     memory read data, valid one cycle after DebugAddress
//   tx_data      byte toward the serial transmitter
//   tx_valid     tx_data holds a byte
//   tx_ready     transmitter accepts the byte this cycle
//   busy         a frame is in progress
//   done         one-cycle pulse after the final byte has been accepted
module debug_dump_unit #(
    parameter int         MEM_WORDS = 32,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        debugMode,
    output logic [31:0] DebugAddress,
    input  logic [31:0] mem_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, HDR, REG_LOAD, MEM_ADDR, MEM_CAP, SEND, CSUM, FIN
    } state_t;

    // Index range is 0..1023, so a 10-bit counter covers every legal MEM_WORDS.
    localparam logic [9:0] LAST_IDX = 10'(MEM_WORDS - 1);

    state_t      state, state_nxt;
    logic [31:0] word_buf;
    logic [1:0]  byte_cnt;
    logic [9:0]  mem_idx;
    logic        mem_phase;   // set once the register words are finished
    logic [7:0]  csum;
    logic        xfer;

    assign xfer         = tx_valid & tx_ready;
    assign DebugAddress = {22'd0, mem_idx};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        debugMode = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = HDR;
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) state_nxt = REG_LOAD;
            end
            REG_LOAD: state_nxt = SEND;
            MEM_ADDR: begin
                debugMode = 1'b1;
                state_nxt = MEM_CAP;
            end
            MEM_CAP: begin
                debugMode = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                tx_valid  = 1'b1;
                debugMode = mem_phase;
                case (byte_cnt)
                    2'd0:    tx_data = word_buf[31:24];
                    2'd1:    tx_data = word_buf[23:16];
                    2'd2:    tx_data = word_buf[15:8];
                    default: tx_data = word_buf[7:0];
                endcase
                if (tx_ready && byte_cnt == 2'd3) begin
                    if (!mem_phase)
                        state_nxt = (reg_sel == 5'd31) ? MEM_ADDR : REG_LOAD;
                    else
                        state_nxt = (mem_idx == LAST_IDX) ? CSUM : MEM_ADDR;
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_sel   <= 5'd0;
            mem_idx   <= 10'd0;
            mem_phase <= 1'b0;
            csum      <= 8'h00;
            byte_cnt  <= 2'd0;
            word_buf  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Fresh frame: rewind both walks and clear the checksum.
                    if (start) begin
                        reg_sel   <= 5'd0;
                        mem_idx   <= 10'd0;
                        mem_phase <= 1'b0;
                        csum      <= 8'h00;
                        byte_cnt  <= 2'd0;
                    end
                end
                REG_LOAD: begin
                    word_buf <= reg_data;
                    byte_cnt <= 2'd0;
                end
                MEM_CAP: begin
                    word_buf <= mem_data;
                    byte_cnt <= 2'd0;
                end
                SEND: begin
                    if (xfer) begin
                        csum     <= csum ^ tx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (!mem_phase) begin
                                if (reg_sel != 5'd31) begin
                                    reg_sel <= reg_sel + 5'd1;
                                end else begin
                                    mem_phase <= 1'b1;
                                    mem_idx   <= 10'd0;
                                end
                            end else if (mem_idx != LAST_IDX) begin
                                // Index is held on the last word so the
                                // address stays put through its final byte.
                                mem_idx <= mem_idx + 10'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Bench for debug_dump_unit: instance 0 uses MEM_WORDS=32, instance 1 uses
// MEM_WORDS=1. A per-cycle monitor compares each instance against a model
// that derives the expected byte at frame position p directly from the
// register/memory contents.
module tb_debug_dump_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a    [2];
    logic        tx_ready_a [2];
    logic [4:0]  reg_sel_a  [2];
    logic [31:0] reg_data_a [2];
    logic        dbg_mode_a [2];
    logic [31:0] dbg_addr_a [2];
    logic [31:0] mem_data_a [2];
    logic [7:0]  tx_data_a  [2];
    logic        tx_valid_a [2];
    logic        busy_a     [2];
    logic        done_a     [2];

    logic [31:0] reg_m [2][32];
    logic [31:0] mem_m [2][32];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    debug_dump_unit #(.MEM_WORDS(32), .HEADER(8'hA5)) dut0 (
        .clk(clk), .reset(reset), .start(start_a[0]), .reg_sel(reg_sel_a[0]),
        .reg_data(reg_data_a[0]), .debugMode(dbg_mode_a[0]),
        .DebugAddress(dbg_addr_a[0]), .mem_data(mem_data_a[0]),
        .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
        .tx_ready(tx_ready_a[0]), .busy(busy_a[0]), .done(done_a[0]));

    debug_dump_unit #(.MEM_WORDS(1), .HEADER(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .start(start_a[1]), .reg_sel(reg_sel_a[1]),
        .reg_data(reg_data_a[1]), .debugMode(dbg_mode_a[1]),
        .DebugAddress(dbg_addr_a[1]), .mem_data(mem_data_a[1]),
        .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
        .tx_ready(tx_ready_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    // External register file (combinational) and data memory (1-cycle read).
    assign reg_data_a[0] = reg_m[0][reg_sel_a[0]];
    assign reg_data_a[1] = reg_m[1][reg_sel_a[1]];
    always @(posedge clk) begin
        mem_data_a[0] <= mem_m[0][dbg_addr_a[0][4:0]];
        mem_data_a[1] <= mem_m[1][dbg_addr_a[1][4:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int mw_of(input int u);
        return (u == 0) ? 32 : 1;
    endfunction

    function automatic int total_of(input int u);
        return 2 + 4 * (32 + mw_of(u));
    endfunction

    function automatic logic [7:0] wbyte(input logic [31:0] w, input int b);
        return 8'(w >> (24 - 8 * b));
    endfunction

    function automatic logic [7:0] exp_byte(input int u, input int p);
        int          mw;
        logic [7:0]  x;
        logic [31:0] w;
        mw = mw_of(u);
        if (p == 0) return 8'hA5;
        if (p <= 128) return wbyte(reg_m[u][(p - 1) / 4], (p - 1) % 4);
        if (p <= 128 + 4 * mw) return wbyte(mem_m[u][(p - 129) / 4], (p - 129) % 4);
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            w = reg_m[u][k];
            x ^= w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        for (int k = 0; k < mw; k++) begin
            w = mem_m[u][k];
            x ^= w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        return x;
    endfunction

    // ---------------- monitor / compare ----------------
    int         n        [2] = '{0, 0};   // bytes transferred this frame
    int         dones    [2] = '{0, 0};
    int         cyc      [2] = '{0, 0};
    int         last_cyc [2] = '{0, 0};
    int         frames   [2] = '{0, 0};
    bit         active   [2] = '{0, 0};
    bit         prev_busy[2] = '{0, 0};
    bit         prev_stall[2] = '{0, 0};
    logic [7:0] prev_data[2];
    logic [7:0] got      [2][300];

    task automatic mon_step(input int u);
        bit exp_dm;
        if (reset) begin
            active[u]     = 0;
            prev_busy[u]  = 0;
            prev_stall[u] = 0;
            return;
        end
        if (busy_a[u] && !prev_busy[u]) begin
            active[u] = 1; n[u] = 0; dones[u] = 0; cyc[u] = 0;
        end
        if (busy_a[u]) begin
            cyc[u]++;
            exp_dm = (n[u] >= 129) && (n[u] < 129 + 4 * mw_of(u));
            chk("debugMode", dbg_mode_a[u], exp_dm);
            if (exp_dm) chk("DebugAddress", dbg_addr_a[u], (n[u] - 129) / 4);
            if (n[u] < 129) chk("reg_sel", reg_sel_a[u], (n[u] == 0) ? 0 : (n[u] - 1) / 4);
            if (done_a[u]) begin
                dones[u]++;
                chk("done_position", n[u], total_of(u));
            end
        end else begin
            chk("idle_outputs", {tx_valid_a[u], done_a[u], dbg_mode_a[u]}, 0);
        end
        if (prev_stall[u]) begin
            chk("stall_hold_valid", tx_valid_a[u], 1);
            chk("stall_hold_data", tx_data_a[u], prev_data[u]);
        end
        if (tx_valid_a[u] && tx_ready_a[u]) begin
            chk("byte", tx_data_a[u], exp_byte(u, n[u]));
            if (n[u] < 300) got[u][n[u]] = tx_data_a[u];
            n[u]++;
        end
        if (!busy_a[u] && prev_busy[u] && active[u]) begin
            chk("frame_len", n[u], total_of(u));
            chk("done_count", dones[u], 1);
            last_cyc[u] = cyc[u];
            frames[u]++;
            active[u] = 0;
        end
        prev_stall[u] = tx_valid_a[u] && !tx_ready_a[u];
        prev_data[u]  = tx_data_a[u];
        prev_busy[u]  = busy_a[u];
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    // ---------------- stimulus ----------------
    // act: 0 plain, 1 stall at byte 2, 2 restart at byte 50,
    //      3 reset at byte 130, 4 random ready / stray starts
    task automatic run_frame(input int u, input int act);
        int f0, stall, budget;
        bit aborted;
        f0 = frames[u]; stall = 0; aborted = 0; budget = 0;
        @(posedge clk); #1;
        start_a[u] = 1; tx_ready_a[u] = 1;
        @(posedge clk); #1;
        start_a[u] = 0;
        while (budget < 5000 && frames[u] == f0 && !aborted) begin
            case (act)
                1: begin
                    if (stall == 0 && n[u] == 2) stall = 7;
                    if (stall > 0) begin
                        chk("stall_valid", tx_valid_a[u], 1);
                        chk("stall_data", tx_data_a[u], 8'h00);
                        tx_ready_a[u] = 0;
                        stall--;
                        if (stall == 0) stall = -1;
                    end else begin
                        tx_ready_a[u] = 1;
                    end
                end
                2: start_a[u] = (n[u] == 50);
                3: if (n[u] == 130) begin
                    chk("pre_reset_debugMode", dbg_mode_a[u], 1);
                    reset = 1;
                    #1;
                    chk("reset_tx_valid", tx_valid_a[u], 0);
                    chk("reset_debugMode", dbg_mode_a[u], 0);
                    chk("reset_busy", busy_a[u], 0);
                    aborted = 1;
                end
                4: begin
                    tx_ready_a[u] = ($urandom_range(0, 3) != 0);
                    start_a[u]    = busy_a[u] && ($urandom_range(0, 40) == 0);
                end
                default: ;
            endcase
            if (!aborted) begin
                @(posedge clk); #1;
            end
            budget++;
        end
        start_a[u] = 0; tx_ready_a[u] = 1;
        if (!aborted) chk("frame_timeout", frames[u], f0 + 1);
    endtask

    initial begin
        reset = 1;
        for (int u = 0; u < 2; u++) begin
            start_a[u] = 0; tx_ready_a[u] = 1;
            for (int k = 0; k < 32; k++) begin reg_m[u][k] = 0; mem_m[u][k] = 0; end
        end
        repeat (2) @(posedge clk); #1;
        chk("rst_state_tx_valid", tx_valid_a[0], 0);
        chk("rst_state_tx_data", tx_data_a[0], 0);
        chk("rst_state_busy", busy_a[0], 0);
        chk("rst_state_done", done_a[0], 0);
        chk("rst_state_reg_sel", reg_sel_a[0], 0);
        chk("rst_state_addr", dbg_addr_a[0], 0);
        chk("rst_state_debugMode", dbg_mode_a[0], 0);
        reset = 0;

        // Known pattern: reg k = k, mem[i] = 0x100+i.
        for (int k = 0; k < 32; k++) begin
            reg_m[0][k] = 32'(k);
            mem_m[0][k] = 32'h100 + 32'(k);
        end
        run_frame(0, 0);
        chk("t1_len", n[0], 258);
        chk("t1_cycles", last_cyc[0], 355);
        chk("t1_hdr", got[0][0], 8'hA5);
        chk("t1_reg1_lsb", got[0][8], 8'h01);
        chk("t1_mem31_b0", got[0][253], 8'h00);
        chk("t1_mem31_b2", got[0][255], 8'h01);
        chk("t1_mem31_b3", got[0][256], 8'h1F);
        chk("t1_csum", got[0][257], 8'h00);

        run_frame(0, 1);
        chk("t2_len", n[0], 258);
        run_frame(0, 2);
        chk("t3_len", n[0], 258);

        run_frame(0, 3);
        repeat (2) begin
            @(posedge clk); #1;
            chk("held_reset_tx_valid", tx_valid_a[0], 0);
        end
        reset = 0;
        run_frame(0, 0);
        chk("t4_hdr", got[0][0], 8'hA5);
        chk("t4_len", n[0], 258);

        mem_m[1][0] = 32'hDEADBEEF;
        run_frame(1, 0);
        chk("t5_len", n[1], 134);
        chk("t5_cycles", last_cyc[1], 169);
        chk("t5_b0", got[1][129], 8'hDE);
        chk("t5_b1", got[1][130], 8'hAD);
        chk("t5_b2", got[1][131], 8'hBE);
        chk("t5_b3", got[1][132], 8'hEF);
        chk("t5_csum", got[1][133], 8'h22);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                reg_m[0][k] = $urandom;
                mem_m[0][k] = $urandom;
            end
            run_frame(0, 4);
            repeat (3) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
